// File: rtl/bbprx_pkg.sv
// Shared types and constants for the baseband pulse receiver trigger/capture gate.
package bbprx_pkg;

    // Video sample width and decimated-sum width, fixed by the settings registers.
    localparam int DATA_W = 12;
    localparam int SUM_W  = 16;
    localparam int CFG_W  = 16;

    localparam logic [DATA_W-1:0] VID_MAX = 12'hFFF;
    localparam logic [SUM_W-1:0]  SUM_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_WAIT_RELAX  = 3'd0,
        ST_WAIT_EXCITE = 3'd1,
        ST_QUALIFY     = 3'd2,
        ST_DELAY       = 3'd3,
        ST_CAPTURE     = 3'd4
    } bbprx_state_t;

endpackage

// File: rtl/decim_accum_bbprx.sv
// Saturating decimating accumulator: sums `decim` samples into one 16-bit result.
module decim_accum_bbprx
    import bbprx_pkg::*;
(
    input  logic              master_clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] din,
    input  logic [CFG_W-1:0]  decim,
    output logic [SUM_W-1:0]  sum,
    output logic              done
);

    logic [SUM_W-1:0] acc_p0;
    logic [CFG_W-1:0] gcnt_p0;
    logic [CFG_W-1:0] gcnt_inc;

    // Adds one video sample to the running sum, clamping at the sum ceiling.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{(SUM_W + 1 - DATA_W){1'b0}}, b};
        return s[SUM_W] ? SUM_MAX : s[SUM_W-1:0];
    endfunction

    // Group completes when this sample is the decim-th one; decim of 0 behaves as 1.
    always_comb begin
        gcnt_inc = gcnt_p0 + 16'd1;
        sum      = sat_add(acc_p0, din);
        done     = add_en && (gcnt_inc >= decim);
    end

    // Running sum and group position; a finished group restarts from zero.
    always_ff @(posedge master_clk) begin
        if (!reset_n || clr) begin
            acc_p0  <= '0;
            gcnt_p0 <= '0;
        end else if (add_en) begin
            if (done) begin
                acc_p0  <= '0;
                gcnt_p0 <= '0;
            end else begin
                acc_p0  <= sum;
                gcnt_p0 <= gcnt_inc;
            end
        end
    end

endmodule

// File: rtl/trig_gate_bbprx.sv
// Radar trigger detector with hysteresis/qualification, programmable delay,
// and a decimated capture window of n_samples outputs per pulse.
module trig_gate_bbprx
    import bbprx_pkg::*;
(
    input  logic              master_clk,
    input  logic              reset_n,
    input  logic              enable_rx,
    input  logic              new_mode,
    input  logic              vid_negate,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_strobe,
    input  logic [DATA_W-1:0] trig_thresh_excite,
    input  logic [DATA_W-1:0] trig_thresh_relax,
    input  logic [CFG_W-1:0]  trig_latency,
    input  logic [CFG_W-1:0]  trig_delay,
    input  logic [CFG_W-1:0]  n_samples,
    input  logic [CFG_W-1:0]  decim_rate,
    output logic              trig_out,
    output logic              capture_active,
    output logic [SUM_W-1:0]  out_data,
    output logic              out_strobe,
    output logic              out_first,
    output logic              missed_trig,
    output logic [CFG_W-1:0]  trig_count
);

    bbprx_state_t state, state_nxt, qual_dst;

    logic [DATA_W-1:0] vid_p0;
    logic              v_hi;
    logic              v_below_relax;
    logic              abort;

    logic [CFG_W-1:0]  qcnt_p0, dcnt_p0, ocnt_p0, trig_cnt_p0;
    logic [CFG_W-1:0]  qcnt_inc, dcnt_inc, ocnt_inc;
    logic              prev_hi_p0;

    // Settings captured at qualification so the pulse in flight is unaffected by changes.
    logic [CFG_W-1:0]  dly_sh, n_sh, dec_sh;

    logic              qualify;
    logic              cap_add;
    logic              cap_done;
    logic              last_grp;
    logic              missed_now;
    logic [SUM_W-1:0]  acc_sum;

    logic              trig_p1, vld_p1, first_p1, cap_p1, miss_p1;
    logic [SUM_W-1:0]  data_p1;

    // ---- stage p0: conditioned video and threshold compares ----
    assign vid_p0        = vid_negate ? (VID_MAX - sample_in) : sample_in;
    assign v_hi          = (vid_p0 >= trig_thresh_excite);
    assign v_below_relax = (vid_p0 < trig_thresh_relax);
    assign abort         = !enable_rx || new_mode;

    assign qcnt_inc = qcnt_p0 + 16'd1;
    assign dcnt_inc = dcnt_p0 + 16'd1;
    assign ocnt_inc = ocnt_p0 + 16'd1;

    // Destination right after qualification, decided from the live settings being latched.
    assign qual_dst = (trig_delay != 16'd0) ? ST_DELAY :
                      (n_samples == 16'd0)  ? ST_WAIT_RELAX : ST_CAPTURE;

    decim_accum_bbprx u_accum (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .clr        (abort || (state != ST_CAPTURE)),
        .add_en     (cap_add),
        .din        (vid_p0),
        .decim      (dec_sh),
        .sum        (acc_sum),
        .done       (cap_done)
    );

    assign last_grp = cap_done && (ocnt_inc == n_sh);

    // State register.
    always_ff @(posedge master_clk) begin
        if (!reset_n) state <= ST_WAIT_RELAX;
        else          state <= state_nxt;
    end

    // Next-state logic; abort overrides everything, otherwise moves only on strobes.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_WAIT_RELAX;
        end else if (sample_strobe) begin
            case (state)
                ST_WAIT_RELAX:  if (v_below_relax) state_nxt = ST_WAIT_EXCITE;
                ST_WAIT_EXCITE: begin
                    if (qualify)   state_nxt = qual_dst;
                    else if (v_hi) state_nxt = ST_QUALIFY;
                end
                ST_QUALIFY: begin
                    if (qualify)    state_nxt = qual_dst;
                    else if (!v_hi) state_nxt = ST_WAIT_EXCITE;
                end
                ST_DELAY: begin
                    if (dcnt_inc == dly_sh)
                        state_nxt = (n_sh == 16'd0) ? ST_WAIT_RELAX : ST_CAPTURE;
                end
                ST_CAPTURE:     if (last_grp) state_nxt = ST_WAIT_RELAX;
                default:        state_nxt = ST_WAIT_RELAX;
            endcase
        end
    end

    // Per-sample events: qualification, capture accumulate, missed-trigger edge.
    always_comb begin
        qualify    = 1'b0;
        cap_add    = 1'b0;
        missed_now = 1'b0;
        if (!abort && sample_strobe) begin
            case (state)
                ST_WAIT_EXCITE: qualify = v_hi && (trig_latency == 16'd0);
                ST_QUALIFY:     qualify = v_hi && (qcnt_p0 >= trig_latency);
                ST_CAPTURE:     cap_add = 1'b1;
                default:        ;
            endcase
            missed_now = v_hi && !prev_hi_p0 &&
                         ((state == ST_DELAY) || (state == ST_CAPTURE));
        end
    end

    // Qualify/delay/output counters and the trigger tally; tally survives aborts.
    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            qcnt_p0     <= '0;
            dcnt_p0     <= '0;
            ocnt_p0     <= '0;
            trig_cnt_p0 <= '0;
            prev_hi_p0  <= 1'b0;
        end else begin
            if (sample_strobe) prev_hi_p0 <= v_hi;
            if (abort) begin
                qcnt_p0 <= '0;
                dcnt_p0 <= '0;
                ocnt_p0 <= '0;
            end else if (qualify) begin
                trig_cnt_p0 <= trig_cnt_p0 + 16'd1;
                qcnt_p0     <= '0;
                dcnt_p0     <= '0;
                ocnt_p0     <= '0;
            end else if (sample_strobe) begin
                case (state)
                    ST_WAIT_EXCITE: if (v_hi) qcnt_p0 <= 16'd1;
                    ST_QUALIFY:     qcnt_p0 <= v_hi ? qcnt_inc : 16'd0;
                    ST_DELAY:       dcnt_p0 <= dcnt_inc;
                    ST_CAPTURE:     if (cap_done) ocnt_p0 <= ocnt_inc;
                    default:        ;
                endcase
            end
        end
    end

    // Shadow copies of the per-pulse settings, taken on qualification.
    always_ff @(posedge master_clk) begin
        if (qualify) begin
            dly_sh <= trig_delay;
            n_sh   <= n_samples;
            dec_sh <= decim_rate;
        end
    end

    // ---- stage p1: registered outputs ----
    // Output registers; abort and reset both force every output low.
    always_ff @(posedge master_clk) begin
        if (!reset_n || abort) begin
            trig_p1  <= 1'b0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            cap_p1   <= 1'b0;
            miss_p1  <= 1'b0;
            data_p1  <= '0;
        end else begin
            trig_p1  <= qualify;
            vld_p1   <= cap_done;
            first_p1 <= cap_done && (ocnt_p0 == 16'd0);
            cap_p1   <= (state_nxt == ST_CAPTURE);
            miss_p1  <= missed_now;
            data_p1  <= cap_done ? acc_sum : '0;
        end
    end

    assign trig_out       = trig_p1;
    assign out_strobe     = vld_p1;
    assign out_first      = first_p1;
    assign out_data       = data_p1;
    assign capture_active = cap_p1;
    assign missed_trig    = miss_p1;
    assign trig_count     = trig_cnt_p0;

endmodule

// File: doc/trig_gate_bbprx.md
# trig_gate_bbprx

Baseband pulse receiver trigger and capture gate. Consumes the trigger and capture settings produced by the master control block, plus the raw 12-bit video sample stream. Detects radar trigger pulses with hysteresis and a qualification latency, waits a programmed delay, then emits `n_samples` decimated, summed video samples per pulse. Output feeds the RX packing/FIFO stage.

## Interface
- No parameters; widths are fixed by the settings registers.
- `master_clk`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable_rx`  in  1  gate enable; low forces abort to WAIT_RELAX.
- `new_mode`  in  1  one-cycle settings-change pulse; forces abort.
- `vid_negate`  in  1  invert video before all processing.
- `sample_in`  in  12  unsigned video sample, valid when `sample_strobe` is high.
- `sample_strobe`  in  1  one cycle per sample; rate arbitrary, including every cycle.
- `trig_thresh_excite`  in  12  trigger rises when video ≥ this value.
- `trig_thresh_relax`  in  12  trigger re-arms when video < this value.
- `trig_latency`  in  16  extra consecutive samples ≥ excite required to qualify a trigger.
- `trig_delay`  in  16  samples skipped between qualification and capture.
- `n_samples`  in  16  output samples per pulse.
- `decim_rate`  in  16  input samples summed per output sample; 0 is treated as 1.
- `trig_out`  out  1  one-cycle pulse on trigger qualification.
- `capture_active`  out  1  high while in CAPTURE.
- `out_data`  out  16  saturating decimated sum.
- `out_strobe`  out  1  one cycle per output sample.
- `out_first`  out  1  high with the first `out_strobe` of each pulse.
- `missed_trig`  out  1  one-cycle pulse when excite is seen during DELAY or CAPTURE.
- `trig_count`  out  16  qualified triggers since reset; wraps.

## Operation
- Video: `v = vid_negate ? 12'hFFF - sample_in : sample_in`. All state advances only on `sample_strobe` cycles.
- States are WAIT_RELAX, WAIT_EXCITE, QUALIFY, DELAY and CAPTURE. Reset state is WAIT_RELAX.
- WAIT_RELAX: on `v < relax`, go to WAIT_EXCITE.
- WAIT_EXCITE: on `v ≥ excite`:
  - If `trig_latency == 0`, qualify immediately.
  - Otherwise go to QUALIFY with `qcnt = 1`.
- QUALIFY: on `v < excite`, return to WAIT_EXCITE. Otherwise increment `qcnt`. When `qcnt == trig_latency`, qualify.
- On qualify:
  - Pulse `trig_out`; increment `trig_count`.
  - Latch `trig_delay`, `n_samples` and `decim_rate` into shadow registers. Later setting changes do not affect the current pulse.
  - If delay > 0, go to DELAY. Otherwise go to CAPTURE; if the latched `n_samples == 0`, go to WAIT_RELAX instead.
- DELAY: count latched-delay samples, then enter CAPTURE. The same n=0 rule applies.
- CAPTURE:
  - Accumulate `v` into a 16-bit sum that saturates at `16'hFFFF`.
  - After `decim_rate` samples, present the sum on `out_data`, pulse `out_strobe`, and clear the accumulator. The next sample starts a fresh sum.
  - After `n_samples` outputs, go to WAIT_RELAX. Re-arming requires video to fall below relax.
- `missed_trig`: pulses on any strobed sample with `v ≥ excite` while in DELAY or CAPTURE, only if the previous strobed sample was `< excite` (rising edge).
- Abort: `enable_rx == 0` or `new_mode == 1` has priority over everything.
  - Go to WAIT_RELAX and clear the accumulator and counters.
  - No `out_strobe` is issued for a partial group.
  - `trig_count` is retained.
- If `excite ≤ relax`, behaviour follows the rules literally; no special-casing.

## Timing
- Reset values: all outputs 0; `trig_count` 0; state WAIT_RELAX; accumulator 0.
- `trig_out` is registered. It is asserted the cycle after the strobed sample that completes qualification.
- `out_strobe`, `out_data` and `out_first` are registered. They are asserted the cycle after the strobed sample completing a group.
- `capture_active` rises the cycle after entry to CAPTURE. It falls the cycle after the final group's sample, coincident with the last `out_strobe`.
- Minimum trigger-to-first-output: with latency=0, delay=0 and decim=1, `out_strobe` arrives 1 cycle after the sample following the trigger sample. The trigger sample itself is not captured.
- Abort takes effect on the next edge; outputs are 0 from then on.

## Structure
- Shared package `bbprx_pkg`:
  - State enum.
  - `VID_MAX = 12'hFFF`.
  - `SUM_MAX = 16'hFFFF`.
- Sub-module `decim_accum_bbprx`:
  - Saturating 16-bit accumulator with group counter, clear, and done flag.
  - Instantiated once in CAPTURE.

## Test plan
- **Basic pulse.** Settings: excite=2000, relax=1000, latency=0, delay=0, n=4, decim=1. Stimulus: strobed ramp 500, 2500, 10, 20, 30, 40. Required: `trig_out` once; outputs 10, 20, 30, 40; `out_first` with 10; `trig_count`=1.
- **Latency and hysteresis.** Settings: latency=2. Stimulus: 2500, 500, 2500, 2500, 2500. Required: first excursion rejected; qualify on the third consecutive sample. Stimulus: without a sample below 1000, a later 2500 burst. Required: no re-trigger.
- **Decimation and saturation.** Settings: decim=20, n=1, inputs constant 4095. Required: `out_data`=16'hFFFF. Settings: decim=3, inputs 1, 2, 3. Required: output 6.
- **Delay and missed trigger.** Settings: delay=5. Stimulus: excite edge during DELAY. Required: `missed_trig` pulse; capture starts after 5 skipped samples; `trig_count` unchanged.
- **Abort mid-capture.** Stimulus: `new_mode` pulse after 2 of 4 outputs. Required: no further `out_strobe`; `capture_active` low next cycle; state WAIT_RELAX.
- **Reset and edge settings.** Stimulus: `reset_n` low mid-CAPTURE. Required: all outputs 0 and `trig_count` 0. Settings: n=0. Required: `trig_out` only, no output. Settings: `vid_negate`=1 with input 0. Required: treated as 4095.
